// File: rtl/bp_network_packet_serializer_if.sv
// bp_network_packet_serializer_if: packet-in / flit-out handshake bundle for the serializer.
// Signals (directions as seen by the serializer, modport slave):
//   valid_i, dest_i, src_i, len_i, data_i : packet offer (valid/ready), ready_o returned
//   valid_o, data_o                       : flit toward the router
//   yumi_i                                : router takes the current flit
// master is the testbench / upstream+router side.
// data_o is one bit wider (even parity on top) when BP_NETWORK_SERIALIZER_PARITY_EN is defined.
interface bp_network_packet_serializer_if #(
    parameter int dest_id_width_p   = 4,
    parameter int src_id_width_p    = 4,
    parameter int payload_width_p   = 64,
    parameter int flit_data_width_p = 16
);
    localparam int num_flits_lp  = (payload_width_p + flit_data_width_p - 1) / flit_data_width_p;
    localparam int idx_width_lp  = (num_flits_lp > 1) ? $clog2(num_flits_lp) : 1;
    localparam int flit_width_lp = dest_id_width_p + src_id_width_p + 1 + idx_width_lp + flit_data_width_p;
`ifdef BP_NETWORK_SERIALIZER_PARITY_EN
    localparam int out_width_lp  = flit_width_lp + 1;
`else
    localparam int out_width_lp  = flit_width_lp;
`endif

    logic                         valid_i;
    logic                         ready_o;
    logic [dest_id_width_p-1:0]   dest_i;
    logic [src_id_width_p-1:0]    src_i;
    logic [idx_width_lp-1:0]      len_i;
    logic [payload_width_p-1:0]   data_i;
    logic                         valid_o;
    logic [out_width_lp-1:0]      data_o;
    logic                         yumi_i;

    modport master (
        output valid_i, dest_i, src_i, len_i, data_i, yumi_i,
        input  ready_o, valid_o, data_o
    );

    modport slave (
        input  valid_i, dest_i, src_i, len_i, data_i, yumi_i,
        output ready_o, valid_o, data_o
    );
endinterface

// File: rtl/bp_network_packet_serializer.sv
// bp_network_packet_serializer: splits one wide packet into a train of header-tagged flits.
// Ports:
//   clk_i      : clock, rising edge
//   reset_n_i  : asynchronous active-low reset
//   bus        : bp_network_packet_serializer_if.slave (packet valid/ready in, flit valid/yumi out)
// data_o = {dest, src, last, idx, flit_data}; flits leave LSB-first, len_i is flit count minus one
// (clamped to the payload size). Defining BP_NETWORK_SERIALIZER_PARITY_EN prepends an even-parity bit.
module bp_network_packet_serializer #(
    parameter int dest_id_width_p   = 4,
    parameter int src_id_width_p    = 4,
    parameter int payload_width_p   = 64,
    parameter int flit_data_width_p = 16
) (
    input logic clk_i,
    input logic reset_n_i,
    bp_network_packet_serializer_if.slave bus
);
    localparam int num_flits_lp  = (payload_width_p + flit_data_width_p - 1) / flit_data_width_p;
    localparam int idx_width_lp  = (num_flits_lp > 1) ? $clog2(num_flits_lp) : 1;
    localparam int flit_width_lp = dest_id_width_p + src_id_width_p + 1 + idx_width_lp + flit_data_width_p;
    localparam int buf_width_lp  = num_flits_lp * flit_data_width_p;
    localparam logic [idx_width_lp-1:0] max_len_lp = idx_width_lp'(num_flits_lp - 1);

    typedef enum logic {IDLE, SEND} state_e;

    state_e                     r_state, w_state_n;
    logic [buf_width_lp-1:0]    r_buf, w_buf_n;
    logic [dest_id_width_p-1:0] r_dest, w_dest_n;
    logic [src_id_width_p-1:0]  r_src, w_src_n;
    logic [idx_width_lp-1:0]    r_len, w_len_n;
    logic [idx_width_lp-1:0]    r_idx, w_idx_n;
    logic [flit_width_lp-1:0]   r_flit, w_flit_n;
    logic                       w_last;
    logic                       w_ready;
    logic                       w_accept;
`ifdef BP_NETWORK_SERIALIZER_PARITY_EN
    logic                       r_par;
`endif

    assign w_last      = r_idx == r_len;
    assign w_ready     = (r_state == IDLE) | ((r_state == SEND) & bus.yumi_i & w_last);
    assign w_accept    = bus.valid_i & w_ready;
    assign bus.ready_o = w_ready;
    assign bus.valid_o = r_state == SEND;
`ifdef BP_NETWORK_SERIALIZER_PARITY_EN
    assign bus.data_o  = {r_par, r_flit};
`else
    assign bus.data_o  = r_flit;
`endif

    // The buffer shifts right on each taken flit, so the current flit is always its low slice.
    // The outgoing flit is built from next-cycle values and registered, which keeps data_o
    // glitch-free and lets the parity bit ride in the same register stage.
    always_comb begin
        w_state_n = r_state;
        w_buf_n   = r_buf;
        w_dest_n  = r_dest;
        w_src_n   = r_src;
        w_len_n   = r_len;
        w_idx_n   = r_idx;
        if (w_accept) begin
            w_state_n = SEND;
            w_buf_n   = '0;
            w_buf_n[payload_width_p-1:0] = bus.data_i;
            w_dest_n  = bus.dest_i;
            w_src_n   = bus.src_i;
            w_len_n   = (bus.len_i > max_len_lp) ? max_len_lp : bus.len_i;
            w_idx_n   = '0;
        end else if ((r_state == SEND) & bus.yumi_i) begin
            if (w_last) begin
                w_state_n = IDLE;
            end else begin
                w_buf_n = r_buf >> flit_data_width_p;
                w_idx_n = r_idx + idx_width_lp'(1);
            end
        end
        w_flit_n = (w_state_n == SEND)
            ? {w_dest_n, w_src_n, w_idx_n == w_len_n, w_idx_n, w_buf_n[flit_data_width_p-1:0]}
            : '0;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_state <= IDLE;
        else            r_state <= w_state_n;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_buf  <= '0;
            r_dest <= '0;
            r_src  <= '0;
            r_len  <= '0;
            r_idx  <= '0;
            r_flit <= '0;
`ifdef BP_NETWORK_SERIALIZER_PARITY_EN
            r_par  <= 1'b0;
`endif
        end else begin
            r_buf  <= w_buf_n;
            r_dest <= w_dest_n;
            r_src  <= w_src_n;
            r_len  <= w_len_n;
            r_idx  <= w_idx_n;
            r_flit <= w_flit_n;
`ifdef BP_NETWORK_SERIALIZER_PARITY_EN
            r_par  <= ^w_flit_n;
`endif
        end
    end
endmodule

// File: tb/tb_bp_network_packet_serializer.sv
// tb_bp_network_packet_serializer: self-checking bench for bp_network_packet_serializer.
module tb_bp_network_packet_serializer;
`ifdef BP_NETWORK_SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int OW = 27 + PAR;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bp_network_packet_serializer_if a_if ();
    bp_network_packet_serializer_if #(.payload_width_p(40)) b_if ();

    bp_network_packet_serializer u_a (.clk_i(clk), .reset_n_i(reset_n), .bus(a_if.slave));
    bp_network_packet_serializer #(.payload_width_p(40)) u_b (.clk_i(clk), .reset_n_i(reset_n), .bus(b_if.slave));

    // Expected flit k of a packet: n = min(len, nf-1)+1 flits, 16-bit chunks of the payload LSB-first.
    function automatic logic [OW-1:0] ref_flit(input logic [3:0] d, input logic [3:0] s, input int len,
                                               input int nf, input logic [63:0] pay, input int k);
        int n;
        logic [26:0] f;
        n = (len < nf ? len : nf - 1) + 1;
        f = {d, s, k == n - 1, 2'(k), 16'(pay >> (16 * k))};
`ifdef BP_NETWORK_SERIALIZER_PARITY_EN
        return {^f, f};
`else
        return f;
`endif
    endfunction

    task automatic drv_a(input logic v, input logic [3:0] d, input logic [3:0] s, input logic [1:0] l,
                         input logic [63:0] x, input logic y);
        @(negedge clk);
        a_if.valid_i = v;
        a_if.dest_i = d;
        a_if.src_i = s;
        a_if.len_i = l;
        a_if.data_i = x;
        a_if.yumi_i = y;
        #1;
    endtask

    task automatic drv_b(input logic v, input logic [3:0] d, input logic [3:0] s, input logic [1:0] l,
                         input logic [39:0] x, input logic y);
        @(negedge clk);
        b_if.valid_i = v;
        b_if.dest_i = d;
        b_if.src_i = s;
        b_if.len_i = l;
        b_if.data_i = x;
        b_if.yumi_i = y;
        #1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (a_if.valid_o !== 1'b0 || a_if.ready_o !== 1'b1 || a_if.data_o !== '0) begin
            bad++;
            $display("FAIL reset_a got v=%b r=%b d=%h want v=0 r=1 d=0", a_if.valid_o, a_if.ready_o, a_if.data_o);
        end
        total++;
        if (b_if.valid_o !== 1'b0 || b_if.ready_o !== 1'b1 || b_if.data_o !== '0) begin
            bad++;
            $display("FAIL reset_b got v=%b r=%b d=%h want v=0 r=1 d=0", b_if.valid_o, b_if.ready_o, b_if.data_o);
        end
    endtask

    task automatic test_basic;
        logic [63:0] x = 64'h1111_2222_3333_4444;
        logic [OW-1:0] e;
        drv_a(1'b1, 4'd3, 4'd5, 2'd3, x, 1'b1);
        total++;
        if (a_if.ready_o !== 1'b1) begin
            bad++;
            $display("FAIL basic_accept got ready=%b want 1", a_if.ready_o);
        end
        for (int k = 0; k < 4; k++) begin
            drv_a(1'b0, 4'd0, 4'd0, 2'd0, 64'd0, 1'b1);
            e = ref_flit(4'd3, 4'd5, 3, 4, x, k);
            total++;
            if (a_if.valid_o !== 1'b1 || a_if.data_o !== e) begin
                bad++;
                $display("FAIL basic_flit%0d got v=%b d=%h want v=1 d=%h", k, a_if.valid_o, a_if.data_o, e);
            end
            total++;
            if (a_if.ready_o !== (k == 3)) begin
                bad++;
                $display("FAIL basic_ready%0d got %b want %b", k, a_if.ready_o, k == 3);
            end
        end
        drv_a(1'b0, 4'd0, 4'd0, 2'd0, 64'd0, 1'b1);
        total++;
        if (a_if.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle got valid=%b want 0", a_if.valid_o);
        end
    endtask

    task automatic test_stall;
        logic [63:0] x = 64'h1111_2222_3333_4444;
        logic [OW-1:0] e;
        int yp[6] = '{1, 0, 0, 1, 1, 1};
        int ip[6] = '{0, 1, 1, 1, 2, 3};
        drv_a(1'b1, 4'd3, 4'd5, 2'd3, x, 1'b1);
        for (int c = 0; c < 6; c++) begin
            drv_a(1'b0, 4'd0, 4'd0, 2'd0, 64'd0, yp[c] == 1);
            e = ref_flit(4'd3, 4'd5, 3, 4, x, ip[c]);
            total++;
            if (a_if.valid_o !== 1'b1 || a_if.data_o !== e) begin
                bad++;
                $display("FAIL stall_flit c%0d got v=%b d=%h want v=1 d=%h", c, a_if.valid_o, a_if.data_o, e);
            end
            total++;
            if (a_if.ready_o !== (c == 5)) begin
                bad++;
                $display("FAIL stall_ready c%0d got %b want %b", c, a_if.ready_o, c == 5);
            end
        end
        drv_a(1'b0, 4'd0, 4'd0, 2'd0, 64'd0, 1'b1);
        total++;
        if (a_if.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL stall_idle got valid=%b want 0", a_if.valid_o);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] x1 = {$urandom, $urandom};
        logic [63:0] x2 = {$urandom, $urandom};
        logic [OW-1:0] e;
        drv_a(1'b1, 4'd1, 4'd2, 2'd1, x1, 1'b1);
        drv_a(1'b0, 4'd0, 4'd0, 2'd0, 64'd0, 1'b1);
        e = ref_flit(4'd1, 4'd2, 1, 4, x1, 0);
        total++;
        if (a_if.data_o !== e) begin
            bad++;
            $display("FAIL b2b_p1f0 got %h want %h", a_if.data_o, e);
        end
        drv_a(1'b1, 4'd7, 4'd4, 2'd1, x2, 1'b1);
        e = ref_flit(4'd1, 4'd2, 1, 4, x1, 1);
        total++;
        if (a_if.ready_o !== 1'b1 || a_if.data_o !== e) begin
            bad++;
            $display("FAIL b2b_p1last got r=%b d=%h want r=1 d=%h", a_if.ready_o, a_if.data_o, e);
        end
        for (int k = 0; k < 2; k++) begin
            drv_a(1'b0, 4'd0, 4'd0, 2'd0, 64'd0, 1'b1);
            e = ref_flit(4'd7, 4'd4, 1, 4, x2, k);
            total++;
            if (a_if.valid_o !== 1'b1 || a_if.data_o !== e) begin
                bad++;
                $display("FAIL b2b_p2f%0d got v=%b d=%h want v=1 d=%h", k, a_if.valid_o, a_if.data_o, e);
            end
        end
        drv_a(1'b0, 4'd0, 4'd0, 2'd0, 64'd0, 1'b1);
        total++;
        if (a_if.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle got valid=%b want 0", a_if.valid_o);
        end
    endtask

    task automatic test_clamp;
        logic [39:0] x = 40'({$urandom, $urandom}) | 40'hFF_0000_0000;
        logic [OW-1:0] e;
        drv_b(1'b1, 4'hA, 4'h3, 2'd3, x, 1'b1);
        total++;
        if (b_if.ready_o !== 1'b1) begin
            bad++;
            $display("FAIL clamp_accept got ready=%b want 1", b_if.ready_o);
        end
        for (int k = 0; k < 3; k++) begin
            drv_b(1'b0, 4'd0, 4'd0, 2'd0, 40'd0, 1'b1);
            e = ref_flit(4'hA, 4'h3, 3, 3, {24'd0, x}, k);
            total++;
            if (b_if.valid_o !== 1'b1 || b_if.data_o !== e) begin
                bad++;
                $display("FAIL clamp_flit%0d got v=%b d=%h want v=1 d=%h", k, b_if.valid_o, b_if.data_o, e);
            end
        end
        total++;
        if (b_if.data_o[15:8] !== 8'h00) begin
            bad++;
            $display("FAIL clamp_pad got %h want 00", b_if.data_o[15:8]);
        end
        drv_b(1'b0, 4'd0, 4'd0, 2'd0, 40'd0, 1'b1);
        total++;
        if (b_if.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL clamp_idle got valid=%b want 0", b_if.valid_o);
        end
    endtask

    task automatic test_parity;
        logic [OW-1:0] e;
        drv_a(1'b1, 4'hF, 4'hF, 2'd0, 64'hFFFF, 1'b1);
        drv_a(1'b0, 4'd0, 4'd0, 2'd0, 64'd0, 1'b1);
        e = ref_flit(4'hF, 4'hF, 0, 4, 64'hFFFF, 0);
        total++;
        if (a_if.data_o !== e) begin
            bad++;
            $display("FAIL par_ones got %h want %h", a_if.data_o, e);
        end
`ifdef BP_NETWORK_SERIALIZER_PARITY_EN
        total++;
        if (a_if.data_o[27] !== 1'b1) begin
            bad++;
            $display("FAIL par_odd got %b want 1", a_if.data_o[27]);
        end
`endif
        drv_a(1'b1, 4'd0, 4'd0, 2'd1, 64'd0, 1'b1);
        drv_a(1'b0, 4'd0, 4'd0, 2'd0, 64'd0, 1'b1);
        total++;
        if (a_if.valid_o !== 1'b1 || a_if.data_o !== '0) begin
            bad++;
            $display("FAIL par_zero got v=%b d=%h want v=1 d=0", a_if.valid_o, a_if.data_o);
        end
        drv_a(1'b0, 4'd0, 4'd0, 2'd0, 64'd0, 1'b1);
        drv_a(1'b0, 4'd0, 4'd0, 2'd0, 64'd0, 1'b0);
        total++;
        if (a_if.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL par_idle got valid=%b want 0", a_if.valid_o);
        end
    endtask

    task automatic test_random;
        logic [OW-1:0] q[$];
        logic [OW-1:0] want;
        logic v, y, wr;
        logic [3:0] d, s;
        logic [1:0] l;
        logic [63:0] x;
        int pk = 0;
        int cyc = 0;
        while ((pk < 40 || q.size() != 0) && cyc < 4000) begin
            v = (pk < 40) && ($urandom_range(0, 1) == 1);
            y = (q.size() != 0) && ($urandom_range(0, 3) != 0);
            d = 4'($urandom);
            s = 4'($urandom);
            l = 2'($urandom);
            x = {$urandom, $urandom};
            drv_a(v, d, s, l, x, y);
            cyc++;
            want = (q.size() != 0) ? q[0] : '0;
            total++;
            if (a_if.valid_o !== (q.size() != 0) || (q.size() != 0 && a_if.data_o !== want)) begin
                bad++;
                $display("FAIL rnd_flit cyc%0d got v=%b d=%h want v=%b d=%h", cyc, a_if.valid_o, a_if.data_o,
                         q.size() != 0, want);
            end
            wr = (q.size() == 0) || (y && q.size() == 1);
            total++;
            if (a_if.ready_o !== wr) begin
                bad++;
                $display("FAIL rnd_ready cyc%0d got %b want %b", cyc, a_if.ready_o, wr);
            end
            if (y) void'(q.pop_front());
            if (v && wr) begin
                for (int k = 0; k <= int'(l); k++) q.push_back(ref_flit(d, s, int'(l), 4, x, k));
                pk++;
            end
        end
        drv_a(1'b0, 4'd0, 4'd0, 2'd0, 64'd0, 1'b0);
        total++;
        if (q.size() != 0 || pk < 40) begin
            bad++;
            $display("FAIL rnd_timeout got pending=%0d packets=%0d want 0 and 40", q.size(), pk);
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] x = {$urandom, $urandom};
        logic [OW-1:0] e;
        drv_a(1'b1, 4'd2, 4'd8, 2'd3, x, 1'b1);
        drv_a(1'b0, 4'd0, 4'd0, 2'd0, 64'd0, 1'b1);
        drv_a(1'b0, 4'd0, 4'd0, 2'd0, 64'd0, 1'b1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (a_if.valid_o !== 1'b0 || a_if.ready_o !== 1'b1 || a_if.data_o !== '0) begin
            bad++;
            $display("FAIL rstmid_abort got v=%b r=%b d=%h want v=0 r=1 d=0", a_if.valid_o, a_if.ready_o, a_if.data_o);
        end
        @(negedge clk);
        reset_n = 1'b1;
        drv_a(1'b1, 4'd9, 4'd6, 2'd0, x, 1'b1);
        total++;
        if (a_if.ready_o !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_accept got ready=%b want 1", a_if.ready_o);
        end
        drv_a(1'b0, 4'd0, 4'd0, 2'd0, 64'd0, 1'b1);
        e = ref_flit(4'd9, 4'd6, 0, 4, x, 0);
        total++;
        if (a_if.valid_o !== 1'b1 || a_if.data_o !== e || a_if.data_o[18:16] !== 3'b100) begin
            bad++;
            $display("FAIL rstmid_flit got v=%b d=%h want v=1 d=%h", a_if.valid_o, a_if.data_o, e);
        end
        drv_a(1'b0, 4'd0, 4'd0, 2'd0, 64'd0, 1'b1);
        total++;
        if (a_if.valid_o !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_idle got valid=%b want 0", a_if.valid_o);
        end
    endtask

    initial begin
        a_if.valid_i = 1'b0;
        a_if.dest_i = '0;
        a_if.src_i = '0;
        a_if.len_i = '0;
        a_if.data_i = '0;
        a_if.yumi_i = 1'b0;
        b_if.valid_i = 1'b0;
        b_if.dest_i = '0;
        b_if.src_i = '0;
        b_if.len_i = '0;
        b_if.data_i = '0;
        b_if.yumi_i = 1'b0;
        test_reset;
        @(negedge clk);
        reset_n = 1'b1;
        test_basic;
        test_stall;
        test_back_to_back;
        test_clamp;
        test_parity;
        test_random;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
